// File: rtl/mul_pkg.sv
// Shared types for the repeated-addition multiplier: controller states,
// default operand width and the controller-to-datapath strobe bundle.
package mul_pkg;

    localparam int WIDTH = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LDB  = 2'd1,
        S_ADD  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    typedef struct packed {
        logic lda;
        logic ldb;
        logic ldp;
        logic clrp;
        logic decb;
    } strobes_t;

endpackage

// File: rtl/mul_datapath.sv
// Datapath for the repeated-addition multiplier: operand A, down-counter B and
// accumulator P, all loaded from the shared bus under controller strobes.
module mul_datapath #(
    parameter int WIDTH = mul_pkg::WIDTH
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] bus,
    input  logic             lda,
    input  logic             ldb,
    input  logic             ldp,
    input  logic             clrp,
    input  logic             decb,
    output logic             eqz,
    output logic [WIDTH-1:0] p
);
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] p_q, p_d;

    always_comb begin
        a_d = a_q;
        b_d = b_q;
        p_d = p_q;
        if (lda) a_d = bus;
        if (ldb) begin
            b_d = bus;
        end else if (decb) begin
            b_d = b_q - 1'b1;
        end
        // The sum is truncated to WIDTH bits, so the product wraps modulo 2^WIDTH.
        if (clrp) begin
            p_d = '0;
        end else if (ldp) begin
            p_d = p_q + a_q;
        end
    end

    // NOTE: A and B carry no reset; they are always reloaded before use, and P is cleared via clrp.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
        p_q <= p_d;
    end

    assign eqz = (b_q == '0);
    assign p   = p_q;

endmodule

// File: rtl/mul_top.sv
// Multiplier wrapper: controller driving the datapath, with the product and
// the zero flag brought out for observation.
module mul_top #(
    parameter int WIDTH = mul_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] p,
    output logic             eqz
);
    logic [WIDTH-1:0] bus;
    logic             lda, ldb, ldp, clrp, decb;

    mul_ctrl #(.WIDTH(WIDTH)) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .eqz       (eqz),
        .bus       (bus),
        .lda       (lda),
        .ldb       (ldb),
        .ldp       (ldp),
        .clrp      (clrp),
        .decb      (decb),
        .busy      (busy),
        .res_valid (res_valid),
        .res_ready (res_ready)
    );

    mul_datapath #(.WIDTH(WIDTH)) u_dp (
        .clk  (clk),
        .bus  (bus),
        .lda  (lda),
        .ldb  (ldb),
        .ldp  (ldp),
        .clrp (clrp),
        .decb (decb),
        .eqz  (eqz),
        .p    (p)
    );

endmodule

// File: rtl/mul_ctrl.sv
// Controller for the repeated-addition multiplier: accepts A then B from a
// valid/ready stream, drives the datapath strobes until B counts down to zero.
module mul_ctrl #(
    parameter int WIDTH = mul_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             eqz,
    output logic [WIDTH-1:0] bus,
    output logic             lda,
    output logic             ldb,
    output logic             ldp,
    output logic             clrp,
    output logic             decb,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready
);
    import mul_pkg::*;

    state_e   state_q, state_d;
    strobes_t stb;

    // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        stb       = '0;
        bus       = '0;
        in_ready  = 1'b0;
        busy      = 1'b0;
        res_valid = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    bus     = in_data;
                    stb.lda = 1'b1;
                    state_d = S_LDB;
                end
            end
            S_LDB: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    bus      = in_data;
                    stb.ldb  = 1'b1;
                    stb.clrp = 1'b1;
                    state_d  = S_ADD;
                end
            end
            S_ADD: begin
                busy = 1'b1;
                // One extra cycle with eqz high ends the loop without touching P.
                if (eqz) begin
                    state_d = S_DONE;
                end else begin
                    stb.ldp  = 1'b1;
                    stb.decb = 1'b1;
                end
            end
            S_DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Reset wins over everything and clears P so an abandoned product never leaks.
        if (rst) begin
            state_d   = S_IDLE;
            stb       = '0;
            stb.clrp  = 1'b1;
            bus       = '0;
            in_ready  = 1'b0;
            busy      = 1'b0;
            res_valid = 1'b0;
        end
    end

    assign lda  = stb.lda;
    assign ldb  = stb.ldb;
    assign ldp  = stb.ldp;
    assign clrp = stb.clrp;
    assign decb = stb.decb;

endmodule

// File: tb/tb_mul_ctrl.sv
// Directed bench: bare mul_ctrl for strobe checks, mul_top alongside it on the
// same stimulus for end-to-end product checks.
module tb_mul_ctrl;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         res_ready;

    logic         in_ready, busy, res_valid;
    logic [W-1:0] bus;
    logic         lda, ldb, ldp, clrp, decb;

    logic         t_in_ready, t_busy, t_res_valid, eqz;
    logic [W-1:0] p;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mul_ctrl #(.WIDTH(W)) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .eqz       (eqz),
        .bus       (bus),
        .lda       (lda),
        .ldb       (ldb),
        .ldp       (ldp),
        .clrp      (clrp),
        .decb      (decb),
        .busy      (busy),
        .res_valid (res_valid),
        .res_ready (res_ready)
    );

    mul_top #(.WIDTH(W)) u_top (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (t_in_ready),
        .busy      (t_busy),
        .res_valid (t_res_valid),
        .res_ready (res_ready),
        .p         (p),
        .eqz       (eqz)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One full operation; gap = idle cycles between A and B, hold = cycles
    // res_ready stays low in DONE, keep_valid holds in_valid high with next_a.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int gap,
                          input int hold, input logic keep_valid, input logic [W-1:0] next_a,
                          input logic [W-1:0] exp_p);
        int n = 0;
        int pulses = 0;
        int viol = 0;
        logic done = 1'b0;

        @(negedge clk);
        in_valid = 1'b1; in_data = a; res_ready = 1'b0;
        #1;
        check("idle_in_ready", in_ready, 1);
        check("lda_on_a", {lda, ldb, ldp, clrp, decb}, 5'b10000);
        check("bus_a", bus, a);

        repeat (gap) begin
            @(negedge clk);
            in_valid = 1'b0; in_data = 16'hDEAD;
            #1;
            if (!in_ready || !busy || lda || ldb || ldp || bus != '0) viol++;
        end

        @(negedge clk);
        in_valid = 1'b1; in_data = b;
        #1;
        check("ldb_on_b", {lda, ldb, ldp, clrp, decb}, 5'b01010);
        check("bus_b", bus, b);

        for (int i = 0; i < 1000 && !done; i++) begin
            @(negedge clk);
            in_valid  = keep_valid;
            in_data   = keep_valid ? next_a : '0;
            res_ready = (hold == 0);
            #1;
            if (res_valid) begin
                done = 1'b1;
            end else begin
                n++;
                if (ldp) pulses++;
                if (ldp != decb || in_ready || !busy || lda || ldb || clrp || bus != '0) viol++;
            end
        end
        check("res_valid_seen", done, 1);
        check("add_cycles", n, b + 1);
        check("ldp_pulses", pulses, b);
        check("product", p, exp_p);
        check("done_flags", {in_ready, busy, lda, ldb, ldp, clrp, decb}, 7'b0);

        if (hold > 0) begin
            repeat (hold) begin
                @(negedge clk);
                #1;
                if (!res_valid || p != exp_p || in_ready || busy || lda || ldb || ldp || clrp || decb) viol++;
            end
            @(negedge clk);
            res_ready = 1'b1;
        end
        check("op_violations", viol, 0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; res_ready = 1'b0;

        @(negedge clk); #1;
        check("rst_strobes", {lda, ldb, ldp, clrp, decb}, 5'b00010);
        check("rst_flags", {in_ready, busy, res_valid}, 3'b000);
        check("rst_bus", bus, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_clrp", clrp, 0);
        check("post_rst_idle", in_ready, 1);
        check("post_rst_p", p, 0);

        // Basic, B=0 and wrap cases.
        run_op(16'd17,    16'd5,   0, 0, 1'b0, '0, 16'd85);
        run_op(16'd1234,  16'd0,   0, 0, 1'b0, '0, 16'd0);
        run_op(16'h4000,  16'd8,   0, 0, 1'b0, '0, 16'h0000);
        run_op(16'd300,   16'd300, 0, 0, 1'b0, '0, 16'h5F90);

        // Backpressure on both sides.
        run_op(16'd25, 16'd7, 3, 10, 1'b0, '0, 16'd175);

        // Reset in the middle of ADD.
        @(negedge clk);
        in_valid = 1'b1; in_data = 16'd9;
        @(negedge clk);
        in_data = 16'd100;
        repeat (40) begin
            @(negedge clk);
            in_valid = 1'b0; in_data = '0;
        end
        #1;
        check("mid_add_busy", busy, 1);
        check("mid_add_p", p, 16'd351);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_strobes", {lda, ldb, ldp, clrp, decb}, 5'b00010);
        check("mid_rst_flags", {in_ready, busy, res_valid}, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("after_rst_idle", {in_ready, busy, res_valid}, 3'b100);
        check("after_rst_p", p, 0);
        run_op(16'd3, 16'd4, 0, 0, 1'b0, '0, 16'd12);

        // Back-to-back with in_valid held high throughout.
        run_op(16'd6,    16'd7, 0, 0, 1'b1, 16'd1000, 16'd42);
        run_op(16'd1000, 16'd3, 0, 0, 1'b1, 16'd0,    16'd3000);
        run_op(16'd0,    16'd5, 0, 0, 1'b0, '0,       16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
